des_key_sched_seq: RTL and testbench
====================================

DES_KEY_SCHED_SEQ -- requirements
Module: des_key_sched_seq

Interface
REQ-001 Parameter NKEYS, default 1, number of 64-bit keys: 1 = single DES, 3 = TDES EDE; any other value SHALL fail elaboration.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 key_in  in  64*NKEYS  K1 in [63:0], K2 in [127:64], K3 in [191:128]; FIPS 46-3 bit 1 = bit 63 of each key; parity bits ignored.
REQ-005 decrypt  in  1  0 = encryption key order, 1 = decryption key order; sampled with key_in.
REQ-006 start_valid / start_ready  in / out  1 each  job request handshake; a job is accepted when both are high at a clock edge.
REQ-007 abort  in  1  synchronous job cancel.
REQ-008 rk  out  48  current round key, PC-2 output, FIPS bit 1 at rk[47].
REQ-009 rk_valid / rk_ready  out / in  1 each  round-key handshake; a key is consumed when both are high at a clock edge.
REQ-010 rk_round  out  4  round index of rk, 0..15 = DES rounds 1..16.
REQ-011 rk_stage  out  2  TDES stage of rk, 0..NKEYS-1.
REQ-012 done  out  1  one-cycle pulse after the last key of a job is consumed.

Function
REQ-013 FSM has two states, IDLE and RUN; start_ready SHALL equal (state==IDLE).
REQ-014 On job acceptance, the FSM SHALL enter RUN, and rk_valid SHALL be 1 in the next cycle, carrying stage 0, round 0.
REQ-015 Stage sequence for encrypt: K1 enc, K2 dec, K3 enc; for decrypt: K3 dec, K2 enc, K1 dec. With NKEYS=1 the sequence is K1 with the decrypt-selected direction.
REQ-016 Enc direction: C/D = PC-1(key); round r key = PC-2 of C/D after cumulative left rotation by shift[0..r], shift = {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}.
REQ-017 Dec direction: round 0 key = PC-2(PC-1(key)) unrotated; round r>0 rotates C/D right by shift[16-r] relative to round r-1. This yields enc keys in reverse order.
REQ-018 C and D registers are 28 bits each and rotate independently; rotation wraps within 28 bits.
REQ-019 rk, rk_round and rk_stage SHALL be driven from registered state only, with no combinational path from any input.
REQ-020 While rk_valid=1 and rk_ready=0, rk, rk_round and rk_stage SHALL hold stable.
REQ-021 On a consumed key, the next key SHALL be valid in the next cycle, giving 1 key/cycle under continuous rk_ready.
REQ-022 After round 15 of stage s<NKEYS-1 is consumed, the next cycle SHALL present stage s+1, round 0, with no bubble; key and direction come from key_in/decrypt captured at acceptance.
REQ-023 key_in and decrypt SHALL be captured at acceptance; later changes have no effect on the job.
REQ-024 After round 15 of the last stage is consumed: the FSM returns to IDLE, rk_valid=0, and done=1 for exactly one cycle. start_ready=1 in that same cycle.
REQ-025 abort=1 in RUN: the next cycle is IDLE with rk_valid=0 and done=0. abort has priority over a simultaneous rk handshake. abort in IDLE has no effect and does not block acceptance.
REQ-026 A job is 16*NKEYS consumed keys; no key is skipped or duplicated.

Reset
REQ-027 rst_n=0 SHALL immediately force: state=IDLE, rk_valid=0, done=0, rk=0, rk_round=0, rk_stage=0, C/D=0, captured key/decrypt=0.
REQ-028 Reset asserted mid-job SHALL discard the job; after rst_n deassertion, start_ready=1 and no done is produced for the discarded job.

Structure
REQ-029 Package des_pkg SHALL hold: the shift table, PC-1 and PC-2 index tables or functions, the state enum, and the key/round-key width constants.
REQ-030 PC-2 SHALL be a combinational sub-module, des_pc2 (56-bit C||D in, 48-bit out), instantiated once.

Verification
REQ-031 NKEYS=1, decrypt=0, key 133457799BBCDFF1, rk_ready=1 -> rk round0=1B02EFFC7072, round15=CB3D8B0E17F5, 16 consecutive valid cycles, then a done pulse.
REQ-032 Same key, decrypt=1 -> round0=CB3D8B0E17F5, round15=1B02EFFC7072; each key equals the enc key of index 15-r.
REQ-033 NKEYS=3, K1=K2=K3=133457799BBCDFF1, encrypt -> 48 keys. Stage1 round0=CB3D8B0E17F5; stage2 round0=1B02EFFC7072; no bubble between stages.
REQ-034 Random rk_ready backpressure (50%) -> rk is stable while stalled, the 16 values match REQ-031, and done appears only after the 16th consumption.
REQ-035 abort asserted at round 7 together with rk_ready=1 -> next cycle rk_valid=0, done=0, start_ready=1, and a new job is accepted the following cycle.
REQ-036 rst_n pulsed low at round 5 -> outputs zero asynchronously, before the next clk edge; after release, a new job produces correct keys from round 0.

Source files
------------

// File: rtl/des_key_sched_seq_pkg.sv
// Shared DES key-schedule constants: widths, FSM states, shift schedule, PC-1/PC-2 tables.
// Bit numbering follows FIPS 46-3: table entry 1 is the MSB of the source vector.
package des_pkg;

  localparam int KEY_W  = 64;
  localparam int RK_W   = 48;
  localparam int CD_W   = 56;
  localparam int HALF_W = 28;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] SHIFT_TAB [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [CD_W-1:0] pc1_permute(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] cd;
    cd = '0;
    for (int i = 0; i < CD_W; i++) begin
      cd[6'(CD_W - 1 - i)] = key[6'(KEY_W - PC1_TAB[i])];
    end
    return cd;
  endfunction

  function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_key_sched_seq_if.sv
// Job-request and round-key stream bundle between a DES datapath (master) and the key scheduler (slave).
interface des_key_sched_seq_if #(
  parameter int NKEYS = 1
);
  import des_pkg::*;

  logic [KEY_W*NKEYS-1:0] key_in;
  logic                   decrypt;
  logic                   start_valid;
  logic                   start_ready;
  logic                   abort;
  logic [RK_W-1:0]        rk;
  logic                   rk_valid;
  logic                   rk_ready;
  logic [3:0]             rk_round;
  logic [1:0]             rk_stage;
  logic                   done;

  modport master (
    output key_in, decrypt, start_valid, abort, rk_ready,
    input  start_ready, rk, rk_valid, rk_round, rk_stage, done
  );

  modport slave (
    input  key_in, decrypt, start_valid, abort, rk_ready,
    output start_ready, rk, rk_valid, rk_round, rk_stage, done
  );

endinterface

// File: rtl/des_key_sched_seq_pc2.sv
// DES PC-2 compression of the 56-bit C||D state to a 48-bit round key.
// Purely combinational, zero latency; no flow control.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0] cd_i,
  output logic [RK_W-1:0] rk_o
);

  always_comb begin
    rk_o = '0;
    for (int i = 0; i < RK_W; i++) begin
      rk_o[6'(RK_W - 1 - i)] = cd_i[6'(CD_W - PC2_TAB[i])];
    end
  end

endmodule

// File: rtl/des_key_sched_seq.sv
// Sequential DES/TDES round-key generator: one 48-bit key per cycle, first key the cycle after acceptance.
// Backpressure: rk_ready=0 freezes the current key; abort drops the job and returns to IDLE next cycle.
module des_key_sched_seq
  import des_pkg::*;
#(
  parameter int NKEYS = 1
) (
  input logic                clk,
  input logic                rst_n,
  des_key_sched_seq_if.slave bus
);

  if (NKEYS != 1 && NKEYS != 3) begin : g_bad_nkeys
    $error("des_key_sched_seq: NKEYS must be 1 or 3");
  end

  localparam logic [1:0] LAST_STAGE = 2'(NKEYS - 1);

  state_e                 state_q, state_d;
  logic [HALF_W-1:0]      c_q, c_d, d_q, d_d;
  logic [KEY_W*NKEYS-1:0] key_q, key_d;
  logic                   dec_q, dec_d;
  logic [3:0]             round_q, round_d;
  logic [1:0]             stage_q, stage_d;
  logic                   done_q, done_d;

  // Stage-load path is shared between job acceptance (fresh key_in) and stage advance (captured keys).
  logic [KEY_W*NKEYS-1:0] src_keys;
  logic [KEY_W-1:0]       kw [4];
  logic                   ld_src_dec, ld_dir_dec;
  logic [1:0]             ld_stage, ld_idx;
  logic [CD_W-1:0]        ld_cd;
  logic [HALF_W-1:0]      ld_c, ld_d;
  logic                   cur_dir_dec;
  logic [1:0]             step_sh;

  for (genvar k = 0; k < 4; k++) begin : g_kw
    if (k < NKEYS) begin : g_used
      assign kw[k] = src_keys[KEY_W*k +: KEY_W];
    end else begin : g_unused
      assign kw[k] = '0;
    end
  end

  always_comb begin
    src_keys   = (state_q == IDLE) ? bus.key_in  : key_q;
    ld_src_dec = (state_q == IDLE) ? bus.decrypt : dec_q;
    ld_stage   = (state_q == IDLE) ? 2'd0 : stage_q + 2'd1;
    // Decrypt walks K3..K1; the middle TDES stage always runs in the opposite direction.
    ld_idx     = ld_src_dec ? (LAST_STAGE - ld_stage) : ld_stage;
    ld_dir_dec = ld_src_dec ^ (ld_stage == 2'd1);
    ld_cd      = pc1_permute(kw[ld_idx]);
    ld_c       = ld_dir_dec ? ld_cd[CD_W-1:HALF_W] : rotl28(ld_cd[CD_W-1:HALF_W], SHIFT_TAB[0]);
    ld_d       = ld_dir_dec ? ld_cd[HALF_W-1:0]    : rotl28(ld_cd[HALF_W-1:0],    SHIFT_TAB[0]);

    cur_dir_dec = dec_q ^ (stage_q == 2'd1);
    step_sh     = cur_dir_dec ? SHIFT_TAB[4'd15 - round_q] : SHIFT_TAB[round_q + 4'd1];
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    key_d   = key_q;
    dec_d   = dec_q;
    round_d = round_q;
    stage_d = stage_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          state_d = RUN;
          key_d   = bus.key_in;
          dec_d   = bus.decrypt;
          round_d = 4'd0;
          stage_d = 2'd0;
          c_d     = ld_c;
          d_d     = ld_d;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.rk_ready) begin
          if (round_q == 4'd15) begin
            if (stage_q == LAST_STAGE) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              stage_d = stage_q + 2'd1;
              round_d = 4'd0;
              c_d     = ld_c;
              d_d     = ld_d;
            end
          end else begin
            round_d = round_q + 4'd1;
            c_d     = cur_dir_dec ? rotr28(c_q, step_sh) : rotl28(c_q, step_sh);
            d_d     = cur_dir_dec ? rotr28(d_q, step_sh) : rotl28(d_q, step_sh);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      key_q   <= '0;
      dec_q   <= 1'b0;
      round_q <= 4'd0;
      stage_q <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      key_q   <= key_d;
      dec_q   <= dec_d;
      round_q <= round_d;
      stage_q <= stage_d;
      done_q  <= done_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_i ({c_q, d_q}),
    .rk_o (bus.rk)
  );

  assign bus.start_ready = (state_q == IDLE);
  assign bus.rk_valid    = (state_q == RUN);
  assign bus.rk_round    = round_q;
  assign bus.rk_stage    = stage_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Bench for des_key_sched_seq: known-answer table, scoreboarded random jobs, abort and reset sequences.
module tb_des_key_sched_seq;

  localparam logic [63:0] KREF = 64'h133457799BBCDFF1;

  logic clk;
  logic rst_n;

  des_key_sched_seq_if #(.NKEYS(1)) if1 ();
  des_key_sched_seq_if #(.NKEYS(3)) if3 ();

  des_key_sched_seq #(.NKEYS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  des_key_sched_seq #(.NKEYS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         sel3;
  logic [191:0] t_key;
  logic         t_dec, t_sv, t_abort, t_rdy;

  assign if1.key_in      = t_key[63:0];
  assign if1.decrypt     = t_dec;
  assign if1.start_valid = t_sv & ~sel3;
  assign if1.abort       = t_abort & ~sel3;
  assign if1.rk_ready    = t_rdy;
  assign if3.key_in      = t_key;
  assign if3.decrypt     = t_dec;
  assign if3.start_valid = t_sv & sel3;
  assign if3.abort       = t_abort & sel3;
  assign if3.rk_ready    = t_rdy;

  logic [47:0] m_rk;
  logic        m_rk_valid, m_done, m_start_ready;
  logic [3:0]  m_rk_round;
  logic [1:0]  m_rk_stage;
  assign m_rk          = sel3 ? if3.rk          : if1.rk;
  assign m_rk_valid    = sel3 ? if3.rk_valid    : if1.rk_valid;
  assign m_done        = sel3 ? if3.done        : if1.done;
  assign m_start_ready = sel3 ? if3.start_ready : if1.start_ready;
  assign m_rk_round    = sel3 ? if3.rk_round    : if1.rk_round;
  assign m_rk_stage    = sel3 ? if3.rk_stage    : if1.rk_stage;

  int n_checks = 0;
  int n_pass   = 0;
  logic [47:0] got [48];

  int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                   19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                   14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                   41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Encryption subkey r: C/D halves rotated left by the cumulative shift count, read via PC-2.
  function automatic logic [47:0] enc_subkey(input logic [63:0] key, input int r);
    bit cd0 [56];
    bit cdr [56];
    int s;
    logic [47:0] k;
    for (int j = 0; j < 56; j++) cd0[j] = key[6'(64 - PC1[j])];
    s = 0;
    for (int i = 0; i <= r; i++) s += SHIFTS[i];
    for (int j = 0; j < 28; j++) begin
      cdr[j]      = cd0[(j + s) % 28];
      cdr[28 + j] = cd0[28 + (j + s) % 28];
    end
    k = '0;
    for (int i = 0; i < 48; i++) k[6'(47 - i)] = cdr[PC2[i] - 1];
    return k;
  endfunction

  task automatic run_job(input bit nk3, input logic [191:0] keys, input bit dec,
                         input int rdy_pct, input int abort_at);
    logic [53:0] expq [$];
    logic [53:0] cur, held;
    logic [63:0] k;
    bit          stalled, kdec;
    int          nk, kidx, idx, cyc;
    nk = nk3 ? 3 : 1;
    for (int s = 0; s < nk; s++) begin
      if (nk == 1)  begin kidx = 0;     kdec = dec;      end
      else if (!dec) begin kidx = s;     kdec = (s == 1); end
      else          begin kidx = 2 - s; kdec = (s != 1); end
      k = (kidx == 0) ? keys[63:0] : (kidx == 1) ? keys[127:64] : keys[191:128];
      for (int r = 0; r < 16; r++)
        expq.push_back({2'(s), 4'(r), kdec ? enc_subkey(k, 15 - r) : enc_subkey(k, r)});
    end

    sel3 = nk3;
    #0;
    chk("start_ready idle", m_start_ready, 1);
    t_key = keys; t_dec = dec; t_sv = 1; t_rdy = 0; t_abort = 0;
    step();
    t_sv = 0;
    t_key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    t_dec = ~dec;
    chk("rk_valid after accept", m_rk_valid, 1);

    idx = 0; stalled = 0; cyc = 0;
    while (idx < expq.size()) begin
      cur = {m_rk_stage, m_rk_round, m_rk};
      chk("rk_valid in job", m_rk_valid, 1);
      chk("done in job", m_done, 0);
      if (stalled) chk("stall hold", cur, held);
      if (abort_at >= 0 && idx == abort_at) begin
        t_abort = 1; t_rdy = 1;
        step();
        t_abort = 0; t_rdy = 0;
        chk("abort rk_valid", m_rk_valid, 0);
        chk("abort done", m_done, 0);
        chk("abort start_ready", m_start_ready, 1);
        return;
      end
      t_rdy = ($urandom_range(99) < rdy_pct);
      if (t_rdy) begin
        chk($sformatf("key s%0d r%0d", idx / 16, idx % 16), cur, expq[idx]);
        got[idx] = m_rk;
        idx++;
        stalled = 0;
      end else begin
        held = cur;
        stalled = 1;
      end
      step();
      cyc++;
      if (cyc > 2000) begin
        fail("job timeout");
        t_rdy = 0;
        return;
      end
    end
    t_rdy = 0;
    chk("done pulse", m_done, 1);
    chk("rk_valid after job", m_rk_valid, 0);
    chk("start_ready with done", m_start_ready, 1);
    step();
    chk("done one cycle", m_done, 0);
  endtask

  typedef struct {
    bit          nk3;
    bit          dec;
    int          idx;
    logic [47:0] exp;
  } vec_t;

  function automatic vec_t mk(input bit nk3, input bit dec, input int idx, input logic [47:0] exp);
    vec_t v;
    v.nk3 = nk3; v.dec = dec; v.idx = idx; v.exp = exp;
    return v;
  endfunction

  initial begin
    vec_t        vq [$];
    logic [191:0] rkeys;
    int          n;

    vq.push_back(mk(0, 0, 0,  48'h1B02EFFC7072));
    vq.push_back(mk(0, 0, 1,  48'h79AED9DBC9E5));
    vq.push_back(mk(0, 0, 2,  48'h55FC8A42CF99));
    vq.push_back(mk(0, 0, 15, 48'hCB3D8B0E17F5));
    vq.push_back(mk(0, 1, 0,  48'hCB3D8B0E17F5));
    vq.push_back(mk(0, 1, 14, 48'h79AED9DBC9E5));
    vq.push_back(mk(0, 1, 15, 48'h1B02EFFC7072));
    vq.push_back(mk(1, 0, 0,  48'h1B02EFFC7072));
    vq.push_back(mk(1, 0, 16, 48'hCB3D8B0E17F5));
    vq.push_back(mk(1, 0, 31, 48'h1B02EFFC7072));
    vq.push_back(mk(1, 0, 32, 48'h1B02EFFC7072));
    vq.push_back(mk(1, 0, 47, 48'hCB3D8B0E17F5));
    vq.push_back(mk(1, 1, 0,  48'hCB3D8B0E17F5));
    vq.push_back(mk(1, 1, 16, 48'h1B02EFFC7072));
    vq.push_back(mk(1, 1, 32, 48'hCB3D8B0E17F5));

    rst_n = 0; sel3 = 0; t_key = '0; t_dec = 0; t_sv = 0; t_abort = 0; t_rdy = 0;
    #3;
    chk("reset rk", if1.rk, 0);
    chk("reset rk_valid", if1.rk_valid, 0);
    chk("reset done", if1.done, 0);
    chk("reset start_ready", if1.start_ready, 1);
    chk("reset rk_round", if1.rk_round, 0);
    chk("reset rk_stage", if3.rk_stage, 0);
    chk("reset rk3", if3.rk, 0);
    #10 rst_n = 1;
    step();

    for (int i = 0; i < vq.size(); i++) begin
      run_job(vq[i].nk3, {KREF, KREF, KREF}, vq[i].dec, 100, -1);
      chk($sformatf("vector %0d", i), got[vq[i].idx], vq[i].exp);
    end

    run_job(0, {128'd0, KREF}, 0, 50, -1);

    run_job(0, {128'd0, KREF}, 0, 100, 7);
    run_job(0, {128'd0, KREF}, 0, 100, -1);

    // abort while IDLE must not block acceptance
    sel3 = 0; t_key = {128'd0, KREF}; t_dec = 0; t_abort = 1; t_sv = 1;
    step();
    t_abort = 0; t_sv = 0;
    chk("idle-abort accept", m_rk_valid, 1);
    chk("idle-abort rk0", m_rk, 48'h1B02EFFC7072);
    t_abort = 1;
    step();
    t_abort = 0;
    chk("abort from run", m_rk_valid, 0);

    // reset mid-job at round 5
    t_key = {128'd0, KREF}; t_sv = 1;
    step();
    t_sv = 0; t_rdy = 1; n = 0;
    while (m_rk_round != 4'd5 && n < 20) begin step(); n++; end
    if (n >= 20) fail("reach round 5");
    #1 rst_n = 0;
    #1;
    chk("async rst rk", m_rk, 0);
    chk("async rst rk_valid", m_rk_valid, 0);
    chk("async rst done", m_done, 0);
    chk("async rst round", m_rk_round, 0);
    chk("async rst start_ready", m_start_ready, 1);
    #2 rst_n = 1; t_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no done after reset", m_done, 0);
    end
    run_job(0, {128'd0, KREF}, 1, 100, -1);

    for (int j = 0; j < 8; j++) begin
      rkeys = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      run_job(1'($urandom_range(1)), rkeys, 1'($urandom_range(1)), (j % 2) ? 50 : 100, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
